// File: rtl/acc_reg.sv
// acc_reg: single accumulator register with load/clear/inc/dec/shift/add
// operations, plus zero, negative and carry/borrow flags.
//
// Control: wen_i is a one-cycle enable, not a handshake. Whenever wen_i is
// high on a rising clock edge, the operation on op_i is applied once on that
// edge. The result and all flags appear on the outputs after that edge. The
// register is always ready, so there is no back-pressure. When wen_i is low,
// or op_i is HOLD, q and all flags keep their values.
// rst_i is synchronous and wins over wen_i/op_i on the same edge.
module acc_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wen_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o
);

    localparam logic [2:0] op_hold = 3'b000;
    localparam logic [2:0] op_load = 3'b001;
    localparam logic [2:0] op_clr  = 3'b010;
    localparam logic [2:0] op_inc  = 3'b011;
    localparam logic [2:0] op_dec  = 3'b100;
    localparam logic [2:0] op_shl  = 3'b101;
    localparam logic [2:0] op_shr  = 3'b110;
    localparam logic [2:0] op_add  = 3'b111;

    localparam logic [WIDTH-1:0] one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] all_ones = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic             z_r;
    logic             n_r;
    logic             c_r;

    logic [WIDTH-1:0] q_next;
    logic             c_next;
    logic             upd;
    logic [WIDTH:0]   add_sum;

    // ADD is evaluated one bit wider so the carry-out lands in the top bit.
    assign add_sum = {1'b0, q_r} + {1'b0, d_i} + {{WIDTH{1'b0}}, cin_i};

    // Next register value and carry for the selected operation.
    // upd is low for HOLD so that flags are left alone as well.
    always_comb begin
        q_next = q_r;
        c_next = c_r;
        upd    = 1'b0;
        if (wen_i) begin
            unique case (op_i)
                op_hold: begin
                    upd = 1'b0;
                end
                op_load: begin
                    upd    = 1'b1;
                    q_next = d_i;
                    c_next = 1'b0;
                end
                op_clr: begin
                    upd    = 1'b1;
                    q_next = '0;
                    c_next = 1'b0;
                end
                op_inc: begin
                    upd    = 1'b1;
                    q_next = q_r + one;
                    c_next = (q_r == all_ones);
                end
                op_dec: begin
                    upd    = 1'b1;
                    q_next = q_r - one;
                    c_next = (q_r == '0);
                end
                op_shl: begin
                    upd    = 1'b1;
                    q_next = {q_r[WIDTH-2:0], cin_i};
                    c_next = q_r[WIDTH-1];
                end
                op_shr: begin
                    upd    = 1'b1;
                    q_next = {cin_i, q_r[WIDTH-1:1]};
                    c_next = q_r[0];
                end
                op_add: begin
                    upd    = 1'b1;
                    q_next = add_sum[WIDTH-1:0];
                    c_next = add_sum[WIDTH];
                end
                default: begin
                    upd = 1'b0;
                end
            endcase
        end
    end

    // State update: reset first, then an enabled non-HOLD operation.
    // z/n are derived from the value being written, never from the old q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_r <= RESET_VAL;
            c_r <= 1'b0;
            z_r <= (RESET_VAL == '0);
            n_r <= RESET_VAL[WIDTH-1];
        end else if (upd) begin
            q_r <= q_next;
            c_r <= c_next;
            z_r <= (q_next == '0);
            n_r <= q_next[WIDTH-1];
        end
    end

    assign q_o = q_r;
    assign z_o = z_r;
    assign n_o = n_r;
    assign c_o = c_r;

endmodule

// File: tb/tb_acc_reg.sv
// Directed bench for acc_reg (WIDTH=8, RESET_VAL=0) with hand-computed
// expected values checked by immediate assertions.
module tb_acc_reg;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] CLR  = 3'b010;
    localparam logic [2:0] INC  = 3'b011;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] SHL  = 3'b101;
    localparam logic [2:0] SHR  = 3'b110;
    localparam logic [2:0] ADD  = 3'b111;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [2:0] op;
    logic [7:0] d;
    logic       cin;
    logic [7:0] q;
    logic       z;
    logic       n;
    logic       c;

    int checks = 0;
    int errors = 0;

    acc_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wen_i (wen),
        .op_i  (op),
        .d_i   (d),
        .cin_i (cin),
        .q_o   (q),
        .z_o   (z),
        .n_o   (n),
        .c_o   (c)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one edge worth of inputs, then settle #1 past the edge
    task automatic apply(input logic r, input logic w, input logic [2:0] o,
                         input logic [7:0] dv, input logic ci);
        rst = r;
        wen = w;
        op  = o;
        d   = dv;
        cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq,
                           input logic ez, input logic en, input logic ec);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".z"}, {7'b0, z}, {7'b0, ez});
        chk({tag, ".n"}, {7'b0, n}, {7'b0, en});
        chk({tag, ".c"}, {7'b0, c}, {7'b0, ec});
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; op = HOLD; d = 8'h00; cin = 1'b0;

        // reset priority over an enabled LOAD
        apply(1, 1, LOAD, 8'hCC, 0);
        chk_all("rst_prio", 8'h00, 1, 0, 0);

        // load and hold
        apply(0, 1, LOAD, 8'hCC, 0);
        chk_all("load_cc", 8'hCC, 0, 1, 0);
        apply(0, 0, LOAD, 8'hFF, 0);
        apply(0, 0, CLR, 8'hFF, 1);
        chk_all("hold_wen0", 8'hCC, 0, 1, 0);
        apply(0, 1, HOLD, 8'h00, 1);
        chk_all("hold_op", 8'hCC, 0, 1, 0);

        // wrap on INC / DEC
        apply(0, 1, LOAD, 8'hFF, 0);
        chk_all("load_ff", 8'hFF, 0, 1, 0);
        apply(0, 1, INC, 8'h00, 0);
        chk_all("inc_wrap", 8'h00, 1, 0, 1);
        apply(0, 0, INC, 8'h00, 0);
        chk_all("hold_carry", 8'h00, 1, 0, 1);
        apply(0, 1, DEC, 8'h00, 0);
        chk_all("dec_wrap", 8'hFF, 0, 1, 1);
        apply(0, 1, DEC, 8'h00, 0);
        chk_all("dec_plain", 8'hFE, 0, 1, 0);

        // shifts
        apply(0, 1, LOAD, 8'h81, 0);
        apply(0, 1, SHL, 8'h00, 0);
        chk_all("shl", 8'h02, 0, 0, 1);
        apply(0, 1, SHR, 8'h00, 1);
        chk_all("shr", 8'h81, 0, 1, 0);
        apply(0, 1, SHR, 8'h00, 0);
        chk_all("shr_c1", 8'h40, 0, 0, 1);
        apply(0, 1, SHL, 8'h00, 1);
        chk_all("shl_cin", 8'h81, 0, 1, 0);

        // add
        apply(0, 1, LOAD, 8'hF0, 0);
        apply(0, 1, ADD, 8'h20, 1);
        chk_all("add_carry", 8'h11, 0, 0, 1);
        apply(0, 1, ADD, 8'h00, 0);
        chk_all("add_zero_op", 8'h11, 0, 0, 0);
        apply(0, 1, ADD, 8'h35, 1);
        chk_all("add_plain", 8'h47, 0, 0, 0);
        apply(0, 1, LOAD, 8'h80, 0);
        apply(0, 1, ADD, 8'h80, 0);
        chk_all("add_to_zero", 8'h00, 1, 0, 1);

        // inc into negative, then clear
        apply(0, 1, LOAD, 8'h7F, 0);
        apply(0, 1, INC, 8'h00, 0);
        chk_all("inc_neg", 8'h80, 0, 1, 0);
        apply(0, 1, CLR, 8'h55, 1);
        chk_all("clr", 8'h00, 1, 0, 0);

        // mid-operation reset, with carry set beforehand
        apply(0, 1, LOAD, 8'hFF, 0);
        apply(0, 1, INC, 8'h00, 0);
        apply(0, 1, LOAD, 8'h55, 0);
        chk_all("pre_rst", 8'h55, 0, 0, 0);
        apply(0, 1, SHL, 8'h00, 0);
        apply(0, 1, SHL, 8'h00, 0);
        chk_all("pre_rst_c", 8'h54, 0, 0, 1);
        apply(1, 1, INC, 8'h00, 0);
        chk_all("mid_rst", 8'h00, 1, 0, 0);
        apply(0, 1, INC, 8'h00, 0);
        chk_all("post_rst_inc", 8'h01, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_reg.md
ACC_REG -- requirements
Module: acc_reg

Interface
REQ-001 Parameter WIDTH, default 8, shall set the data width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0, shall set the WIDTH-bit value loaded into the register on reset.
REQ-003 Port clk_i  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  shall be the reset, synchronous and active-high.
REQ-005 Port wen_i  input  1  shall enable the selected operation when high; low means hold.
REQ-006 Port op_i  input  3  shall select the operation (see REQ-010).
REQ-007 Port d_i  input  WIDTH  shall be the data operand for LOAD and ADD.
REQ-008 Port cin_i  input  1  shall be the carry-in / shift-in bit for SHL, SHR and ADD.
REQ-009 Ports q_o (output, WIDTH, register value), z_o (output, 1, zero flag), n_o (output, 1, negative flag = q_o MSB) and c_o (output, 1, carry/borrow flag) shall be driven directly from registers.

Function
REQ-010 op_i encoding shall be: 000 HOLD, 001 LOAD, 010 CLR, 011 INC, 100 DEC, 101 SHL, 110 SHR, 111 ADD.
REQ-011 Operations shall take effect on the rising edge where wen_i=1; latency one cycle, results visible on q_o/flags after that edge.
REQ-012 With wen_i=0, or wen_i=1 and op HOLD, q_o, z_o, n_o and c_o shall all retain their values.
REQ-013 LOAD: q <= d_i; c <= 0.
REQ-014 CLR: q <= 0; c <= 0.
REQ-015 INC: q <= q+1 modulo 2^WIDTH; c <= 1 only when q was all ones (wrap to 0).
REQ-016 DEC: q <= q-1 modulo 2^WIDTH; c <= 1 (borrow) only when q was 0 (wrap to all ones).
REQ-017 SHL: q <= {q[WIDTH-2:0], cin_i}; c <= old q[WIDTH-1].
REQ-018 SHR: q <= {cin_i, q[WIDTH-1:1]}; c <= old q[0].
REQ-019 ADD: {c, q} <= q + d_i + cin_i, computed in WIDTH+1 bits; c is the carry-out.
REQ-020 For every non-HOLD enabled operation, z <= (new q == 0) and n <= new q[WIDTH-1], both computed from the value being written, not the old value.
REQ-021 Flags shall never change on cycles where q_o does not update.
REQ-022 Outputs shall have no combinational path from any input.

Reset
REQ-023 When rst_i=1 at a rising edge: q <= RESET_VAL, c <= 0, z <= (RESET_VAL==0), n <= RESET_VAL[WIDTH-1].
REQ-024 Reset shall take priority over wen_i and op_i on the same edge.
REQ-025 Before the first reset edge, output values are unspecified; benches shall apply reset for at least one edge.
REQ-026 Operation shall resume on the first edge with rst_i=0, using the reset value as the old q.

Verification (WIDTH=8, RESET_VAL=0)
REQ-027 Reset priority: rst_i=1, wen_i=1, LOAD, d_i=0xCC for one edge -> q_o=0x00, z_o=1, n_o=0, c_o=0.
REQ-028 Load/hold: LOAD 0xCC -> q_o=0xCC (204), n_o=1, z_o=0; then wen_i=0, d_i=0xFF for 2 edges -> q_o stays 0xCC, flags unchanged.
REQ-029 Wrap: LOAD 0xFF, INC -> q_o=0x00, z_o=1, c_o=1; DEC -> q_o=0xFF, c_o=1, n_o=1, z_o=0.
REQ-030 Shifts: LOAD 0x81, SHL cin_i=0 -> q_o=0x02, c_o=1; SHR cin_i=1 -> q_o=0x81, c_o=0, n_o=1.
REQ-031 Add: LOAD 0xF0, ADD d_i=0x20 cin_i=1 -> q_o=0x11, c_o=1, z_o=0, n_o=0.
REQ-032 Mid-operation reset: q_o=0x55, rst_i=1 with INC enabled -> q_o=0x00, flags at reset values; release rst_i, INC -> q_o=0x01, c_o=0.
